sar_search: RTL and testbench

Successive-approximation search controller that finds an unknown N-bit value by driving trial values into an external magnitude comparator and consuming its greater/lesser/equal flags. It sits on the driving side of the comparator: the unknown operand feeds the comparator's A input, this block drives B through `trial`, and the comparator's three flags come back combinationally in the same cycle. A search runs MSB to LSB, one bit per clock, and reports the recovered value with a one-cycle `done` pulse.

---
 rtl/sar_search_if.sv | 24 ++
 rtl/sar_search.sv | 89 ++++++++
 tb/tb_sar_search.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sar_search_if.sv
// Handshake and comparator bundle between the SAR search controller and its driver.
interface sar_search_if #(
   parameter int N = 8
);
   logic         start;
   logic         greater;
   logic         lesser;
   logic         equal;
   logic [N-1:0] trial;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         err;

   modport master (
      output start, greater, lesser, equal,
      input  trial, busy, done, result, err
   );

   modport slave (
      input  start, greater, lesser, equal,
      output trial, busy, done, result, err
   );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search controller driving an external magnitude comparator.
// Optional feature: define SAR_EARLY_EXIT_EN to finish a search as soon as the comparator reports equal.
module sar_search #(
   parameter int N = 8
) (
   input  logic        clk,
   input  logic        rst,
   sar_search_if.slave bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SEARCH = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]   state;
   logic [N-1:0] acc;
   logic [N-1:0] mask;
   logic [N-1:0] result_r;
   logic         err_r;
   logic [N-1:0] trial_w;
   logic [N-1:0] acc_nxt;
   logic         early_w;

   // Exactly one of three flags: odd population, but not all three.
   function automatic logic flags_onehot(input logic g, input logic l, input logic e);
      return (g ^ l ^ e) & ~(g & l & e);
   endfunction

   assign trial_w = acc | mask;
   assign acc_nxt = (bus.greater || bus.equal) ? trial_w : acc;

`ifdef SAR_EARLY_EXIT_EN
   assign early_w = bus.equal;
`else
   assign early_w = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         acc      <= '0;
         mask     <= '0;
         result_r <= '0;
         err_r    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state <= S_SEARCH;
                  acc   <= '0;
                  mask  <= {1'b1, {(N-1){1'b0}}};
                  err_r <= 1'b0;
               end
            end
            S_SEARCH: begin
               if (!flags_onehot(bus.greater, bus.lesser, bus.equal)) begin
                  // Inconsistent comparator: report what was recovered so far.
                  err_r    <= 1'b1;
                  result_r <= acc;
                  mask     <= '0;
                  state    <= S_DONE;
               end else begin
                  acc <= acc_nxt;
                  if (early_w || mask[0]) begin
                     result_r <= acc_nxt;
                     mask     <= '0;
                     state    <= S_DONE;
                  end else begin
                     mask <= mask >> 1;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.trial  = trial_w;
   assign bus.busy   = (state == S_SEARCH);
   assign bus.done   = (state == S_DONE);
   assign bus.result = result_r;
   assign bus.err    = err_r;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: behavioural comparator, hand-computed trial sequences and results.
module tb_sar_search;

   localparam int N = 8;
`ifdef SAR_EARLY_EXIT_EN
   localparam int LEN_80 = 1;
   localparam int GAP_3C = 8;
`else
   localparam int LEN_80 = 8;
   localparam int GAP_3C = 10;
`endif

   logic         clk;
   logic         rst;
   logic [N-1:0] unk;
   logic         force_bad;
   int           n_checks;
   int           n_fail;
   logic [N-1:0] trial_log [0:63];
   logic [N-1:0] seq_a5 [0:7];

   sar_search_if #(.N(N)) bus ();

   sar_search #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Behavioural comparator; force_bad makes greater and lesser both high.
   assign bus.greater = force_bad ? 1'b1 : (unk > bus.trial);
   assign bus.lesser  = force_bad ? 1'b1 : (unk < bus.trial);
   assign bus.equal   = force_bad ? 1'b0 : (unk == bus.trial);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_search(input string tag, input logic [N-1:0] u, input int bad_idx,
                             input int exp_len, input logic [N-1:0] exp_res, input logic exp_err);
      int cyc;
      unk = u;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (bus.busy && cyc < 40) begin
         trial_log[cyc] = bus.trial;
         force_bad = (cyc == bad_idx);
         cyc++;
         @(negedge clk);
      end
      force_bad = 1'b0;
      check({tag, "_len"},    cyc,        exp_len);
      check({tag, "_done"},   bus.done,   1'b1);
      check({tag, "_result"}, bus.result, exp_res);
      check({tag, "_err"},    bus.err,    exp_err);
      check({tag, "_trial"},  bus.trial,  exp_res);
      @(negedge clk);
      check({tag, "_done_off"}, bus.done, 1'b0);
      check({tag, "_result_hold"}, bus.result, exp_res);
   endtask

   initial begin
      int cyc;
      int t0;
      int t1;
      int dcount;
      n_checks  = 0;
      n_fail    = 0;
      force_bad = 1'b0;
      unk       = 8'h00;
      bus.start = 1'b0;
      seq_a5[0] = 8'h80; seq_a5[1] = 8'hC0; seq_a5[2] = 8'hA0; seq_a5[3] = 8'hB0;
      seq_a5[4] = 8'hA8; seq_a5[5] = 8'hA4; seq_a5[6] = 8'hA6; seq_a5[7] = 8'hA5;

      rst = 1'b1;
      #2;
      check("rst_trial",  bus.trial,  8'h00);
      check("rst_busy",   bus.busy,   1'b0);
      check("rst_done",   bus.done,   1'b0);
      check("rst_result", bus.result, 8'h00);
      check("rst_err",    bus.err,    1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Basic search with full trial sequence.
      run_search("a5", 8'hA5, -1, 8, 8'hA5, 1'b0);
      for (int i = 0; i < 8; i++) check($sformatf("a5_trial%0d", i), trial_log[i], seq_a5[i]);

      run_search("z00", 8'h00, -1, 8, 8'h00, 1'b0);
      check("z00_last_trial", trial_log[7], 8'h01);
      run_search("ff", 8'hFF, -1, 8, 8'hFF, 1'b0);
      check("ff_last_trial", trial_log[7], 8'hFF);

      run_search("m80", 8'h80, -1, LEN_80, 8'h80, 1'b0);

      // Non-one-hot flags on the third evaluation.
      run_search("bad", 8'hA5, 2, 3, 8'h80, 1'b1);

      // A clean search clears err.
      run_search("a5b", 8'hA5, -1, 8, 8'hA5, 1'b0);

      // start held high: back-to-back searches.
      unk = 8'h3C;
      @(negedge clk);
      bus.start = 1'b1;
      cyc = 0;
      t0 = -1;
      t1 = -1;
      while (cyc < 100 && t1 < 0) begin
         @(negedge clk);
         cyc++;
         if (bus.done) begin
            if (t0 < 0) begin
               t0 = cyc;
               check("b2b_result0", bus.result, 8'h3C);
            end else begin
               t1 = cyc;
            end
         end
      end
      check("b2b_gap", t1 - t0, GAP_3C);
      check("b2b_result1", bus.result, 8'h3C);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Reset during the 4th SEARCH cycle.
      unk = 8'hA5;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_busy",  bus.busy,  1'b1);
      check("pre_rst_trial", bus.trial, 8'hB0);
      #1 rst = 1'b1;
      #1;
      check("arst_trial",  bus.trial,  8'h00);
      check("arst_busy",   bus.busy,   1'b0);
      check("arst_done",   bus.done,   1'b0);
      check("arst_result", bus.result, 8'h00);
      check("arst_err",    bus.err,    1'b0);
      #1 rst = 1'b0;
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done) dcount++;
      end
      check("arst_no_done", dcount, 0);
      run_search("post_rst", 8'hA5, -1, 8, 8'hA5, 1'b0);
      for (int i = 0; i < 8; i++) check($sformatf("post_trial%0d", i), trial_log[i], seq_a5[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
